audio_out_fifo: RTL and testbench
=================================

# audio_out_fifo

Stereo sample FIFO between the moving-average filter and the audio codec write port. Accepts one filtered left/right 24-bit sample pair per valid strobe and drains pairs to the codec whenever the codec reports space. Decouples the filter's update cadence from the codec's write_ready cadence and flags overruns and starvation.

## Interface
- DEPTH, 8, number of stereo pairs stored; power of two, ≥ 2
- W, 24, sample width in bits (two's complement, passed through untouched)

- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  synchronous, active-low reset
- in_valid  input  1  filter presents a new pair this cycle
- in_left  input  W  left sample
- in_right  input  W  right sample
- in_ready  output  1  FIFO can accept a pair (= not full)
- write_ready  input  1  codec can accept a pair this cycle
- write  output  1  pair presented to codec this cycle
- writedata_left  output  W  head-of-FIFO left sample
- writedata_right  output  W  head-of-FIFO right sample
- count  output  $clog2(DEPTH)+1  pairs currently stored, 0..DEPTH
- overflow  output  1  sticky: a pair was offered while full
- underflow  output  1  sticky: codec asked for data while empty after priming

## Operation
- Storage: DEPTH-entry array of {left,right}; rd_ptr, wr_ptr each $clog2(DEPTH) bits, wrap modulo DEPTH; count tracks occupancy.
- push = in_valid && in_ready; writes pair at wr_ptr, wr_ptr+1.
- in_ready = (count != DEPTH). in_valid while full: pair dropped, no state change other than overflow flag.
- write = write_ready && (count != 0) && reset_n; combinational from registered state plus write_ready.
- pop = write; rd_ptr+1 at edge. writedata_* always show entry at rd_ptr (first-word fall-through); content undefined-but-stable when empty, write low.
- count next: +1 on push only, −1 on pop only, unchanged on both or neither.
- Push and pop in same cycle: legal for 0 < count < DEPTH; at count = DEPTH push refused (in_ready low), pop proceeds; at count = 0 pop impossible, push proceeds.
- primed: internal bit, set on first push after reset.
- Reset (reset_n low at edge): rd_ptr, wr_ptr, count, primed, overflow, underflow ← 0. Reset mid-stream discards stored pairs; array contents need not be cleared. While reset_n low, write = 0 and in_ready reflects pre-edge state but no push is committed.

## Timing
- Reset values: in_ready 1, write 0, count 0, overflow 0, underflow 0.
- Push at edge k: pair visible on writedata_* and count updated from cycle k+1; write may assert in cycle k+1 if write_ready high (1-cycle latency).
- Pop at edge k: next pair on writedata_* from cycle k+1.
- No combinational path from in_valid to write, nor from write_ready to in_ready.
- Max throughput: one push and one pop per cycle.

## Configuration
- AUDIO_FIFO_STATUS_EN defined: overflow set at edge where in_valid && count == DEPTH; underflow set at edge where write_ready && count == 0 && primed; both hold until reset.
- Not defined: overflow and underflow tied to 0; no flag or primed logic synthesised; all other behaviour identical.

## Test plan
- Reset then push 3 pairs (L=0x000010/R=0xFFFFF0, L=0x000020/R=0xFFFFE0, L=0x000030/R=0xFFFFD0) with write_ready=0 -> count=3, write=0, writedata_left=0x000010.
- Raise write_ready for 3 cycles -> write high 3 cycles, writedata_left 0x000010, 0x000020, 0x000030 in order, count returns 0, write drops.
- Fill to DEPTH=8, then in_valid with L=0x7FFFFF while write_ready=0 -> in_ready=0, count=8, pair dropped; with macro overflow=1, without overflow=0; drained data contains no 0x7FFFFF.
- Steady state count=4, in_valid and write_ready high 20 cycles -> count stays 4, output order equals input order, pointers wrap without loss.
- After priming and draining to empty, write_ready high 1 cycle -> write=0; with macro underflow=1 and stays 1; before any push, write_ready high -> underflow stays 0.
- reset_n low for 1 cycle with count=5 -> next cycle count=0, write=0, in_ready=1, flags 0; subsequent push of 0x000123 appears as first output.

Source files
------------

// File: rtl/audio_out_fifo.sv
// Stereo sample FIFO between the moving-average filter and the codec write port.
// Define AUDIO_FIFO_STATUS_EN to build the sticky overflow/underflow status flags.
module audio_out_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 24
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     in_valid,
   input  logic [W-1:0]             in_left,
   input  logic [W-1:0]             in_right,
   output logic                     in_ready,
   input  logic                     write_ready,
   output logic                     write,
   output logic [W-1:0]             writedata_left,
   output logic [W-1:0]             writedata_right,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [2*W-1:0] mem_q [DEPTH];
   logic [AW-1:0]  wrPtr_q, wrPtr_d;
   logic [AW-1:0]  rdPtr_q, rdPtr_d;
   logic [CW-1:0]  count_q, count_d;
   logic           push, pop;

   // Flow control depends only on registered occupancy, so write_ready never reaches in_ready.
   assign in_ready        = (count_q != FULL);
   assign write           = write_ready && (count_q != '0) && reset_n;
   assign push            = in_valid && in_ready && reset_n;
   assign pop             = write;
   assign writedata_left  = mem_q[rdPtr_q][2*W-1:W];
   assign writedata_right = mem_q[rdPtr_q][W-1:0];
   assign count           = count_q;

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (push) wrPtr_d = wrPtr_q + 1'b1;
      if (pop)  rdPtr_d = rdPtr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // Sample storage is never cleared; stale entries are unreachable after a reset.
   always_ff @(posedge clk) begin
      if (push) mem_q[wrPtr_q] <= {in_left, in_right};
   end

`ifdef AUDIO_FIFO_STATUS_EN
   logic primed_q, overflow_q, underflow_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         primed_q    <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (push) primed_q <= 1'b1;
         if (in_valid && count_q == FULL) overflow_q <= 1'b1;
         if (write_ready && count_q == '0 && primed_q) underflow_q <= 1'b1;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_audio_out_fifo.sv
// Self-checking bench for audio_out_fifo against a queue-based reference model.
module tb_audio_out_fifo;

   localparam int DEPTH = 8;
   localparam int W     = 24;

`ifdef AUDIO_FIFO_STATUS_EN
   localparam bit STATUS_EN = 1'b1;
`else
   localparam bit STATUS_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          in_valid = 1'b0;
   logic [W-1:0]  in_left = '0;
   logic [W-1:0]  in_right = '0;
   logic          in_ready;
   logic          write_ready = 1'b0;
   logic          write;
   logic [W-1:0]  writedata_left;
   logic [W-1:0]  writedata_right;
   logic [3:0]    count;
   logic          overflow;
   logic          underflow;

   int checks = 0;
   int errors = 0;

   logic [2*W-1:0] modelQ[$];
   bit  modelPrimed = 0;
   bit  modelOvf = 0;
   bit  modelUnf = 0;
   bit  seenDropped = 0;

   audio_out_fifo #(.DEPTH(DEPTH), .W(W)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid),
      .in_left(in_left), .in_right(in_right), .in_ready(in_ready),
      .write_ready(write_ready), .write(write),
      .writedata_left(writedata_left), .writedata_right(writedata_right),
      .count(count), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Compare every visible output against what the model says before the coming edge.
   task automatic checkOutput();
      chk("in_ready", 48'(in_ready), 48'(modelQ.size() != DEPTH));
      chk("write", 48'(write), 48'(write_ready && modelQ.size() != 0 && reset_n));
      chk("count", 48'(count), 48'(modelQ.size()));
      chk("overflow", 48'(overflow), 48'(modelOvf));
      chk("underflow", 48'(underflow), 48'(modelUnf));
      if (modelQ.size() != 0) begin
         chk("writedata_left", 48'(writedata_left), 48'(modelQ[0][2*W-1:W]));
         chk("writedata_right", 48'(writedata_right), 48'(modelQ[0][W-1:0]));
      end
   endtask

   // Drive one cycle of inputs, check outputs mid-cycle, then advance the model at the edge.
   task automatic applyStimulus(input bit v, input logic [W-1:0] l, input logic [W-1:0] r,
                                input bit wr, input bit rn);
      logic [2*W-1:0] front;
      bit doPush, doPop;
      @(negedge clk);
      in_valid = v; in_left = l; in_right = r; write_ready = wr; reset_n = rn;
      #1;
      checkOutput();
      @(posedge clk);
      if (!rn) begin
         modelQ.delete();
         modelPrimed = 0; modelOvf = 0; modelUnf = 0;
      end else begin
         doPush = v && modelQ.size() < DEPTH;
         doPop  = wr && modelQ.size() > 0;
         if (STATUS_EN && v && modelQ.size() == DEPTH) modelOvf = 1;
         if (STATUS_EN && wr && modelQ.size() == 0 && modelPrimed) modelUnf = 1;
         if (doPop) begin
            front = modelQ.pop_front();
            if (front[2*W-1:W] == 24'h7FFFFF) seenDropped = 1;
         end
         if (doPush) begin
            modelQ.push_back({l, r});
            modelPrimed = 1;
         end
      end
   endtask

   initial begin
      logic [W-1:0] d;

      applyStimulus(0, '0, '0, 0, 0);
      applyStimulus(0, '0, '0, 0, 0);
      // Starvation before any push must not raise underflow.
      applyStimulus(0, '0, '0, 1, 1);
      applyStimulus(0, '0, '0, 1, 1);

      applyStimulus(1, 24'h000010, 24'hFFFFF0, 0, 1);
      applyStimulus(1, 24'h000020, 24'hFFFFE0, 0, 1);
      applyStimulus(1, 24'h000030, 24'hFFFFD0, 0, 1);
      for (int i = 0; i < 4; i++) applyStimulus(0, '0, '0, 1, 1);
      applyStimulus(0, '0, '0, 0, 1);

      applyStimulus(0, '0, '0, 0, 0);
      for (int i = 0; i < DEPTH; i++) applyStimulus(1, W'(i + 1), W'(32'hABC000 + i), 0, 1);
      applyStimulus(1, 24'h7FFFFF, 24'h7FFFFF, 0, 1);
      applyStimulus(1, 24'h7FFFFF, 24'h7FFFFF, 0, 1);
      for (int i = 0; i < DEPTH + 2; i++) applyStimulus(0, '0, '0, 1, 1);
      applyStimulus(0, '0, '0, 0, 1);
      chk("dropped_pair_absent", 48'(seenDropped), 48'(0));

      applyStimulus(0, '0, '0, 0, 0);
      for (int i = 0; i < 4; i++) applyStimulus(1, W'(32'h100 + i), W'(32'h200 + i), 0, 1);
      for (int i = 0; i < 20; i++) applyStimulus(1, W'(32'h300 + i), ~W'(32'h300 + i), 1, 1);
      applyStimulus(0, '0, '0, 0, 1);

      applyStimulus(0, '0, '0, 0, 0);
      for (int i = 0; i < 5; i++) applyStimulus(1, W'(32'h50 + i), W'(32'h60 + i), 0, 1);
      applyStimulus(1, 24'h000999, 24'h000999, 1, 0);
      applyStimulus(1, 24'h000123, 24'hFFFEDD, 0, 1);
      applyStimulus(0, '0, '0, 1, 1);
      applyStimulus(0, '0, '0, 1, 1);

      for (int i = 0; i < 400; i++) begin
         d = W'($urandom);
         applyStimulus(bit'($urandom_range(0, 99) < 55), d, ~d,
                       bit'($urandom_range(0, 99) < 50), bit'($urandom_range(0, 63) != 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
